ahb_sram_slave: RTL and testbench

Bus responder for the cache bus unit's simplified AHB (haddr/hwrite/hburst/htrans/hwdata → hrdata/hready/hresp). It backs an on-chip synchronous SRAM window and answers single reads, single writes and incrementing read/write bursts with a configurable number of wait states. Out-of-window and read-only-violating accesses get a two-cycle error response. It sits on the AHB fabric as the target the cache controller's bus unit refills lines from.

---
 rtl/ahb_sram_slave.sv | 123 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | ahb_sram_slave : simplified-AHB responder backed by a synchronous SRAM |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module ahb_sram_slave #(
    parameter int BUS_WIDTH   = 8,
    parameter int BUS_ADDR    = 24,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_STATES = 0,
    parameter int RO_LIMIT    = 0
) (
    input  logic                 clk,
    input  logic                 hreset_n,
    input  logic                 hsel,
    input  logic [BUS_ADDR-1:0]  haddr,
    input  logic                 hwrite,
    input  logic                 hburst,
    input  logic                 htrans,
    input  logic [BUS_WIDTH-1:0] hwdata,
    output logic [BUS_WIDTH-1:0] hrdata,
    output logic                 hready,
    output logic                 hresp
);

    localparam int                OFF_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [BUS_ADDR:0] DEPTH_LIM = (BUS_ADDR+1)'(MEM_DEPTH);
    localparam logic [3:0]        WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   addr_q, addr_d;
    logic               write_q, write_d;
    logic [3:0]         wait_q, wait_d;
    logic               rvalid_q, rvalid_d;
    logic [BUS_WIDTH-1:0] ram_rd_q;
    logic [BUS_WIDTH-1:0] mem [MEM_DEPTH];

    logic w_accept, w_oob, w_ro, w_err, w_commit, w_rd_issue, w_fwd;
    logic w_unused_hburst;

    assign w_unused_hburst = hburst;

    // Read-only window check only exists when a protected region is configured
    generate
        if (RO_LIMIT > 0) begin : g_ro
            localparam logic [BUS_ADDR:0] RO_LIM = (BUS_ADDR+1)'(RO_LIMIT);
            assign w_ro = ({1'b0, haddr} < RO_LIM);
        end else begin : g_no_ro
            assign w_ro = 1'b0;
        end
    endgenerate

    assign hready     = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign hresp      = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign w_accept   = hsel & htrans & hready;
    assign w_oob      = ({1'b0, haddr} >= DEPTH_LIM);
    assign w_err      = w_oob | (hwrite & w_ro);
    assign w_commit   = (state_q == S_DATA) & write_q;
    assign w_rd_issue = w_accept & ~w_err & ~hwrite;
    assign w_fwd      = w_rd_issue & w_commit & (haddr[OFF_W-1:0] == addr_q);
    assign hrdata     = rvalid_q ? ram_rd_q : '0;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wait_d   = wait_q;
        rvalid_d = rvalid_q;
        case (state_q)
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_DATA;
                else                wait_d  = wait_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                if (w_accept) begin
                    addr_d  = haddr[OFF_W-1:0];
                    write_d = hwrite;
                    wait_d  = WAIT_INIT;
                    if (!hwrite) rvalid_d = ~w_err;
                    if (w_err)                 state_d = S_ERR1;
                    else if (WAIT_STATES > 0)  state_d = S_WAIT;
                    else                       state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wait_q   <= 4'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
        end
    end

    // SRAM array is not reset; a read of the word being written returns the new data
    always_ff @(posedge clk) begin
        if (w_commit)   mem[addr_q] <= hwdata;
        if (w_rd_issue) ram_rd_q    <= w_fwd ? hwdata : mem[haddr[OFF_W-1:0]];
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ahb_sram_slave : directed self-checking bench for ahb_sram_slave    |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        hreset_n;
    logic        hsel0, hsel2;
    logic [23:0] haddr;
    logic        hwrite, hburst, htrans;
    logic [7:0]  hwdata;
    logic [7:0]  hrdata0, hrdata2;
    logic        hready0, hready2, hresp0, hresp2;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int rdy_cnt;
    int bad_cnt;

    always #5 clk = ~clk;

    ahb_sram_slave #(.BUS_WIDTH(8), .BUS_ADDR(24), .MEM_DEPTH(4096),
                     .WAIT_STATES(0), .RO_LIMIT(16)) u_dut0 (
        .clk(clk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr),
        .hwrite(hwrite), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
    );

    ahb_sram_slave #(.BUS_WIDTH(8), .BUS_ADDR(24), .MEM_DEPTH(4096),
                     .WAIT_STATES(2), .RO_LIMIT(0)) u_dut2 (
        .clk(clk), .hreset_n(hreset_n), .hsel(hsel2), .haddr(haddr),
        .hwrite(hwrite), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata2), .hready(hready2), .hresp(hresp2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = 1'b0;
        hwrite = 1'b0;
    endtask

    initial begin
        hreset_n = 1'b0;
        bus_idle();
        haddr  = '0;
        hwdata = '0;
        hburst = 1'b0;
        u_dut0.mem[0] = 8'h3C;
        #12;
        check("rst0_hready", hready0, 1);
        check("rst0_hresp",  hresp0,  0);
        check("rst0_hrdata", hrdata0, 0);
        check("rst2_hready", hready2, 1);
        check("rst2_hresp",  hresp2,  0);
        check("rst2_hrdata", hrdata2, 0);
        @(negedge clk);
        hreset_n = 1'b1;
        tick();

        // single write 0x5A to 0x010, then single read
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b1; haddr = 24'h000010;
        tick();
        check("wr_data_ready", hready0, 1);
        hwdata = 8'h5A;
        bus_idle();
        tick();
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b0; haddr = 24'h000010;
        tick();
        check("rd_ready",  hready0, 1);
        check("rd_hresp",  hresp0,  0);
        check("rd_hrdata", hrdata0, 8'h5A);
        bus_idle();
        tick();

        // write 0xA5 to 0x020 followed at once by a read of 0x020
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b1; haddr = 24'h000020;
        tick();
        hwdata = 8'hA5;
        hwrite = 1'b0;
        tick();
        check("fwd_ready",  hready0, 1);
        check("fwd_hrdata", hrdata0, 8'hA5);
        bus_idle();
        tick();

        // 256-beat write burst, word = offset[7:0]
        hburst = 1'b1;
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b1; haddr = 24'h000100;
        rdy_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (hready0 === 1'b1) rdy_cnt++;
            hwdata = 8'(i);
            if (i < 255) haddr = 24'(32'h101 + i);
            else         bus_idle();
        end
        tick();
        check("bwr_ready_cnt", rdy_cnt, 256);

        // 256-beat read burst
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b0; haddr = 24'h000100;
        rdy_cnt = 0;
        bad_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (hready0 === 1'b1 && hresp0 === 1'b0) rdy_cnt++;
            if (hrdata0 !== 8'(i)) bad_cnt++;
            if (i < 255) haddr = 24'(32'h101 + i);
            else         bus_idle();
        end
        check("brd_ready_cnt", rdy_cnt, 256);
        check("brd_data_errs", bad_cnt, 0);
        hburst = 1'b0;
        tick();

        // read at offset MEM_DEPTH
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b0; haddr = 24'h001000;
        tick();
        bus_idle();
        check("oob_err1_ready", hready0, 0);
        check("oob_err1_hresp", hresp0,  1);
        tick();
        check("oob_err2_ready",  hready0, 1);
        check("oob_err2_hresp",  hresp0,  1);
        check("oob_err2_hrdata", hrdata0, 0);
        tick();
        check("post_err_ready", hready0, 1);
        check("post_err_hresp", hresp0,  0);

        // write into the read-only window
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b1; haddr = 24'h000000;
        tick();
        bus_idle();
        hwdata = 8'h77;
        check("ro_err1_ready", hready0, 0);
        check("ro_err1_hresp", hresp0,  1);
        tick();
        check("ro_err2_ready", hready0, 1);
        check("ro_err2_hresp", hresp0,  1);
        tick();
        hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b0; haddr = 24'h000000;
        tick();
        bus_idle();
        check("ro_keep_hrdata", hrdata0, 8'h3C);
        check("ro_keep_hresp",  hresp0,  0);
        tick();

        // two wait states: write 0x66 to 0x030, junk hwdata during waits
        hsel2 = 1'b1; htrans = 1'b1; hwrite = 1'b1; haddr = 24'h000030;
        tick();
        bus_idle();
        hwdata = 8'hEE;
        check("ws_wr_w1", hready2, 0);
        tick();
        check("ws_wr_w2", hready2, 0);
        tick();
        check("ws_wr_data", hready2, 1);
        hwdata = 8'h66;
        tick();
        hwdata = 8'hEE;

        hsel2 = 1'b1; htrans = 1'b1; hwrite = 1'b0; haddr = 24'h000030;
        tick();
        bus_idle();
        check("ws_rd_w1", hready2, 0);
        tick();
        check("ws_rd_w2", hready2, 0);
        tick();
        check("ws_rd_ready",  hready2, 1);
        check("ws_rd_hresp",  hresp2,  0);
        check("ws_rd_hrdata", hrdata2, 8'h66);
        tick();

        // reset while a write sits in its wait states
        hsel2 = 1'b1; htrans = 1'b1; hwrite = 1'b1; haddr = 24'h000030;
        tick();
        bus_idle();
        hwdata = 8'h99;
        check("rstw_in_wait", hready2, 0);
        hreset_n = 1'b0;
        #1;
        check("rstw_hready", hready2, 1);
        check("rstw_hresp",  hresp2,  0);
        check("rstw_hrdata", hrdata2, 0);
        tick();
        tick();
        tick();
        @(negedge clk);
        hreset_n = 1'b1;
        tick();
        hsel2 = 1'b1; htrans = 1'b1; hwrite = 1'b0; haddr = 24'h000030;
        tick();
        bus_idle();
        tick();
        tick();
        check("rstw_keep_ready",  hready2, 1);
        check("rstw_keep_hrdata", hrdata2, 8'h66);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
